spmv_result_collector: RTL and testbench

Downstream stage of the sparse matrix-vector multiply top level. Captures the paired row results that the multiplier emits on `op1`/`op2` with their row address `addrext`, and stores them in an even/odd-banked result buffer. After the multiplier signals completion, the block drains every row `0..nrows-1` in ascending order over a valid/ready stream, substituting zero for rows never written.

---
 rtl/spmv_pkg.sv | 15 +
 rtl/spmv_result_collector_if.sv | 31 +++
 rtl/result_bank.sv | 22 ++
 rtl/spmv_result_collector.sv | 167 ++++++++++++++++
 tb/tb_spmv_result_collector.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spmv_pkg.sv
// Shared constants and types for the SpMV datapath and its result collector.
package spmv_pkg;
  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int NROWS = 1 << AW;

  typedef logic [AW-1:0] row_t;
  typedef logic [DW-1:0] word_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } coll_state_t;
endpackage

// File: rtl/spmv_result_collector_if.sv
// Multiplier-beat input, control pulses and drain stream of the result collector.
interface spmv_result_collector_if #(
  parameter int DW = spmv_pkg::DW,
  parameter int AW = spmv_pkg::AW
);
  logic          valid;
  logic          zeros;
  logic [AW-1:0] addrext;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic          done_mul;
  logic [AW:0]   nrows;
  logic          start;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_row;
  logic          out_last;
  logic          drain_done;
  logic          collect_err;

  modport master (
    output valid, zeros, addrext, op1, op2, done_mul, nrows, start, out_ready,
    input  out_valid, out_data, out_row, out_last, drain_done, collect_err
  );

  modport slave (
    input  valid, zeros, addrext, op1, op2, done_mul, nrows, start, out_ready,
    output out_valid, out_data, out_row, out_last, drain_done, collect_err
  );
endinterface

// File: rtl/result_bank.sv
// One bank of the result buffer: simple dual-port RAM, one write and one
// synchronous read per cycle; read data holds while no read is issued.
module result_bank #(
  parameter int DEPTH = 512,
  parameter int ABITS = 9,
  parameter int DW    = 64
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [DW-1:0]    rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/spmv_result_collector.sv
// Captures paired row results into even/odd banks, then drains rows 0..nrows-1
// in order through a 2-entry skid output, zero-filling rows never written.
module spmv_result_collector #(
  parameter int DW    = spmv_pkg::DW,
  parameter int AW    = spmv_pkg::AW,
  parameter int NROWS = spmv_pkg::NROWS
) (
  input logic                    clk,
  input logic                    reset,
  spmv_result_collector_if.slave bus
);
  import spmv_pkg::*;

  localparam int          BAW     = AW - 1;
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  coll_state_t      state;
  logic [NROWS-1:0] written;
  logic [AW:0]      nrows_lat;
  logic [AW:0]      rd_ptr;
  logic             err;
  logic             drain_done;

  logic             s1_vld, s1_hit, s1_last;
  logic [AW-1:0]    s1_row;
  logic             sk_vld, sk_last;
  logic [AW-1:0]    sk_row;
  logic [DW-1:0]    sk_data;

  logic             collect, wr_a, wr_b, dup, stray;
  logic [AW:0]      b_full;
  logic [AW-1:0]    a_row, b_row;
  logic [DW-1:0]    a_dat, b_dat;
  logic             even_we, odd_we;
  logic [BAW-1:0]   even_waddr, odd_waddr;
  logic [DW-1:0]    even_wdata, odd_wdata, even_rdata, odd_rdata, s1_data;
  logic             issue, last_rd, s1_take, s1_park, accept;

  assign collect = (state == ST_COLLECT);
  assign a_row   = bus.addrext;
  assign b_full  = {1'b0, bus.addrext} + CNT_ONE;
  assign b_row   = b_full[AW-1:0];
  assign wr_a    = collect & bus.valid;
  // b_full equals NROWS for the top row, so this also stops a wrap onto row 0
  assign wr_b    = wr_a & (b_full < bus.nrows);
  assign a_dat   = bus.zeros ? '0 : bus.op1;
  assign b_dat   = bus.zeros ? '0 : bus.op2;

  assign even_we    = (wr_a & ~a_row[0]) | (wr_b & ~b_row[0]);
  assign odd_we     = (wr_a & a_row[0]) | (wr_b & b_row[0]);
  assign even_waddr = a_row[0] ? b_row[AW-1:1] : a_row[AW-1:1];
  assign odd_waddr  = a_row[0] ? a_row[AW-1:1] : b_row[AW-1:1];
  assign even_wdata = a_row[0] ? b_dat : a_dat;
  assign odd_wdata  = a_row[0] ? a_dat : b_dat;

  assign dup   = (wr_a & written[a_row]) | (wr_b & written[b_row]);
  assign stray = bus.valid & ~collect;

  // A new read is only launched while the skid entry is free, so bank read
  // data stays parked under s1 for as long as s1 is waiting.
  assign issue   = (state == ST_DRAIN) & ~sk_vld & (rd_ptr < nrows_lat);
  assign last_rd = (rd_ptr == (nrows_lat - CNT_ONE));
  assign s1_data = s1_hit ? (s1_row[0] ? odd_rdata : even_rdata) : '0;
  assign s1_take = s1_vld & ~sk_vld & bus.out_ready;
  assign s1_park = s1_vld & ~sk_vld & ~bus.out_ready & issue;
  assign accept  = bus.out_valid & bus.out_ready;

  assign bus.out_valid   = sk_vld | s1_vld;
  assign bus.out_data    = sk_vld ? sk_data : s1_data;
  assign bus.out_row     = sk_vld ? sk_row : s1_row;
  assign bus.out_last    = sk_vld ? sk_last : s1_last;
  assign bus.drain_done  = drain_done;
  assign bus.collect_err = err;

  result_bank #(.DEPTH(NROWS/2), .ABITS(BAW), .DW(DW)) u_even (
    .clk   (clk),
    .we    (even_we),
    .waddr (even_waddr),
    .wdata (even_wdata),
    .re    (issue),
    .raddr (rd_ptr[AW-1:1]),
    .rdata (even_rdata)
  );

  result_bank #(.DEPTH(NROWS/2), .ABITS(BAW), .DW(DW)) u_odd (
    .clk   (clk),
    .we    (odd_we),
    .waddr (odd_waddr),
    .wdata (odd_wdata),
    .re    (issue),
    .raddr (rd_ptr[AW-1:1]),
    .rdata (odd_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_COLLECT;
      written    <= '0;
      nrows_lat  <= '0;
      rd_ptr     <= '0;
      err        <= 1'b0;
      drain_done <= 1'b0;
      s1_vld     <= 1'b0;
      s1_hit     <= 1'b0;
      s1_last    <= 1'b0;
      s1_row     <= '0;
      sk_vld     <= 1'b0;
      sk_last    <= 1'b0;
      sk_row     <= '0;
      sk_data    <= '0;
    end else if (bus.start) begin
      state      <= ST_COLLECT;
      written    <= '0;
      rd_ptr     <= '0;
      err        <= 1'b0;
      drain_done <= 1'b0;
      s1_vld     <= 1'b0;
      s1_hit     <= 1'b0;
      sk_vld     <= 1'b0;
    end else begin
      if (wr_a) written[a_row] <= 1'b1;
      if (wr_b) written[b_row] <= 1'b1;
      if (dup | stray) err <= 1'b1;

      case (state)
        ST_COLLECT: begin
          if (bus.done_mul) begin
            nrows_lat <= bus.nrows;
            rd_ptr    <= '0;
            if (bus.nrows == '0) begin
              state      <= ST_DONE;
              drain_done <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && bus.out_last) begin
            state      <= ST_DONE;
            drain_done <= 1'b1;
          end
        end
        default: ;
      endcase

      if (issue) begin
        rd_ptr  <= rd_ptr + CNT_ONE;
        s1_vld  <= 1'b1;
        s1_row  <= rd_ptr[AW-1:0];
        s1_hit  <= written[rd_ptr[AW-1:0]];
        s1_last <= last_rd;
      end else if (s1_take) begin
        s1_vld <= 1'b0;
      end

      if (s1_park) begin
        sk_vld  <= 1'b1;
        sk_data <= s1_data;
        sk_row  <= s1_row;
        sk_last <= s1_last;
      end else if (sk_vld && bus.out_ready) begin
        sk_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spmv_result_collector.sv
// Randomised and directed scoreboard bench for the SpMV result collector.
module tb_spmv_result_collector;
  import spmv_pkg::*;

  typedef struct {
    row_t  row;
    word_t data;
    bit    last;
  } exp_t;

  logic clk;
  logic reset;

  spmv_result_collector_if bus ();
  spmv_result_collector dut (.clk(clk), .reset(reset), .bus(bus));

  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    n_acc = 0;
  int    last_acc_cyc = 0;
  int    rdy_mode = 0;
  int    cur_n = 0;
  exp_t  q[$];
  word_t m_mem [NROWS];
  bit    m_wr [NROWS];
  bit    m_err = 0;
  bit    m_collect = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: a row store plus a written flag per row.
  function automatic void model_write(input int r, input word_t v);
    if (m_wr[r]) m_err = 1;
    m_wr[r]  = 1;
    m_mem[r] = v;
  endfunction

  function automatic void model_beat(input int a, input word_t o1, input word_t o2, input bit z);
    if (!m_collect) begin
      m_err = 1;
      return;
    end
    model_write(a, z ? '0 : o1);
    if ((a + 1 < cur_n) && (a + 1 < NROWS)) model_write(a + 1, z ? '0 : o2);
  endfunction

  initial begin
    int k;
    k = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (k % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  end

  initial begin : monitor
    exp_t  e;
    bit    held;
    word_t h_data;
    row_t  h_row;
    logic  h_last;
    held = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 0;
      end else begin
        if (held) begin
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, h_data);
          chk("stall_row", bus.out_row, h_row);
          chk("stall_last", bus.out_last, h_last);
        end
        held = 0;
        if (bus.out_valid) begin
          if (bus.out_ready) begin
            if (q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_word: row %0d data %0h arrived, scoreboard empty", bus.out_row, bus.out_data);
            end else begin
              e = q.pop_front();
              chk("word_row", bus.out_row, e.row);
              chk("word_data", bus.out_data, e.data);
              chk("word_last", bus.out_last, e.last);
              n_acc++;
              if (e.last) last_acc_cyc = cyc;
            end
          end else begin
            held   = 1;
            h_data = bus.out_data;
            h_row  = bus.out_row;
            h_last = bus.out_last;
          end
        end
      end
    end
  end

  task automatic begin_scenario(input int n);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int r = 0; r < NROWS; r++) m_wr[r] = 0;
    m_err     = 0;
    m_collect = 1;
    cur_n     = n;
    bus.nrows = n[AW:0];
    @(negedge clk);
    chk("start_clears_err", bus.collect_err, 0);
    chk("start_clears_done", bus.drain_done, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int a, input word_t o1, input word_t o2, input bit z);
    bus.valid   = 1'b1;
    bus.zeros   = z;
    bus.addrext = a[AW-1:0];
    bus.op1     = o1;
    bus.op2     = o2;
    model_beat(a, o1, o2, z);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.zeros = 1'b0;
  endtask

  task automatic pulse_done(input bit wb, input int a, input word_t o1, input word_t o2, input bit z);
    exp_t e;
    if (wb) begin
      bus.valid   = 1'b1;
      bus.zeros   = z;
      bus.addrext = a[AW-1:0];
      bus.op1     = o1;
      bus.op2     = o2;
      model_beat(a, o1, o2, z);
    end
    bus.done_mul = 1'b1;
    if (m_collect) begin
      m_collect = 0;
      for (int r = 0; r < cur_n; r++) begin
        e.row  = r[AW-1:0];
        e.data = m_wr[r] ? m_mem[r] : '0;
        e.last = (r == cur_n - 1);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.done_mul = 1'b0;
    bus.valid    = 1'b0;
    bus.zeros    = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", bus.out_valid, 0);
    if (cur_n == 0) begin
      chk("empty_done_next_cycle", bus.drain_done, 1);
    end else begin
      @(negedge clk);
      chk("lat_cycle2_valid", bus.out_valid, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit chk_timing);
    bit seen;
    seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.drain_done) begin
        seen = 1;
        break;
      end
    end
    chk("drain_done_seen", seen, 1);
    if (seen && chk_timing) chk("drain_done_timing", cyc, last_acc_cyc + 1);
    chk("all_drained", q.size(), 0);
    chk("collect_err", bus.collect_err, m_err);
    @(negedge clk);
    chk("no_extra_word", bus.out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    reset        = 1'b1;
    bus.valid    = 1'b0;
    bus.zeros    = 1'b0;
    bus.addrext  = '0;
    bus.op1      = '0;
    bus.op2      = '0;
    bus.done_mul = 1'b0;
    bus.nrows    = '0;
    bus.start    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_drain_done", bus.drain_done, 0);
    chk("rst_collect_err", bus.collect_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Full fill
    begin_scenario(8);
    rdy_mode = 0;
    for (int r = 0; r < 8; r += 2) drive_beat(r, word_t'(r * 10), word_t'(r * 10 + 10), 0);
    pulse_done(0, 0, '0, '0, 0);
    wait_done(1);

    // Odd alignment with holes
    begin_scenario(5);
    drive_beat(1, 64'hA, 64'hB, 0);
    pulse_done(0, 0, '0, '0, 0);
    wait_done(1);

    // Zeros beat and lane-B drop at the nrows edge
    begin_scenario(3);
    drive_beat(2, 64'd5, 64'd9, 0);
    drive_beat(0, 64'd7, 64'd7, 1);
    pulse_done(0, 0, '0, '0, 0);
    wait_done(1);

    // Backpressure 1,0,0 pattern
    begin_scenario(4);
    rdy_mode = 1;
    drive_beat(0, 64'h11, 64'h22, 0);
    drive_beat(2, 64'h33, 64'h44, 0);
    pulse_done(0, 0, '0, '0, 0);
    wait_done(1);

    // Duplicate write, then a beat coincident with done_mul
    begin_scenario(6);
    rdy_mode = 0;
    drive_beat(2, 64'd1, 64'd2, 0);
    drive_beat(3, 64'd77, 64'd8, 0);
    @(negedge clk);
    chk("dup_sets_err", bus.collect_err, 1);
    @(posedge clk);
    #1;
    pulse_done(1, 0, 64'd100, 64'd101, 0);
    wait_done(1);

    // Empty drain, stray beat in DONE, then a cleared bitmap
    begin_scenario(0);
    pulse_done(0, 0, '0, '0, 0);
    wait_done(0);
    drive_beat(4, 64'd1, 64'd1, 0);
    @(negedge clk);
    chk("stray_valid_err", bus.collect_err, 1);
    @(posedge clk);
    #1;
    begin_scenario(6);
    pulse_done(0, 0, '0, '0, 0);
    wait_done(1);

    // Reset in the middle of a drain
    begin_scenario(6);
    for (int r = 0; r < 6; r += 2) drive_beat(r, word_t'(r + 1), word_t'(r + 2), 0);
    base = n_acc;
    pulse_done(0, 0, '0, '0, 0);
    for (int i = 0; i < 50 && n_acc < base + 2; i++) begin
      @(negedge clk);
      #1;
    end
    chk("two_accepts_before_reset", n_acc - base, 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_out_row", bus.out_row, 0);
    chk("midrst_out_last", bus.out_last, 0);
    chk("midrst_drain_done", bus.drain_done, 0);
    q.delete();
    for (int r = 0; r < NROWS; r++) m_wr[r] = 0;
    m_err     = 0;
    m_collect = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_reset_no_word", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    cur_n     = 2;
    bus.nrows = 11'd2;
    pulse_done(0, 0, '0, '0, 0);
    wait_done(1);

    // Randomised scenarios; the first covers the full depth and the top row
    for (int t = 0; t < 8; t++) begin
      int n;
      int nb;
      int a;
      n = (t == 0) ? NROWS : $urandom_range(1, 48);
      begin_scenario(n);
      rdy_mode = $urandom_range(0, 2);
      nb = $urandom_range(0, n / 2 + 2);
      for (int b = 0; b < nb; b++) begin
        a = (t == 0 && b == 0) ? NROWS - 1 : $urandom_range(0, n - 1);
        drive_beat(a, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 7) == 0);
      end
      a = $urandom_range(0, n - 1);
      pulse_done(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, {$urandom, $urandom}, 0);
      wait_done(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
